// File: rtl/tdm4_pkg.sv
// tdm4_pkg: shared types and slot-search helper for the four-channel TDM transmitter
package tdm4_pkg;
    localparam int NUM_CH = 4;
    typedef logic [1:0] slot_t;
    typedef enum logic [1:0] {IDLE, RUN, STOP} state_t;
    // returns {found, channel}: first full channel at or after start, round-robin
    function automatic logic [2:0] next_full(input logic [NUM_CH-1:0] full, input slot_t start);
        logic [2:0] r;
        slot_t idx;
        r = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            idx = start + slot_t'(k);
            if (full[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction
endpackage

// File: rtl/tdm4_chan_buf.sv
// tdm4_chan_buf: one-entry per-channel holding register with full flag and ready
module tdm4_chan_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    input  logic             drain,
    output logic             in_ready,
    output logic [WIDTH-1:0] hold,
    output logic             full
);
    assign in_ready = ~full;
    // a capture into an empty register wins over a drain of that same (empty) slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full <= 1'b0;
            hold <= '0;
        end else if (in_valid && !full) begin
            full <= 1'b1;
            hold <= in_data;
        end else if (drain) begin
            full <= 1'b0;
        end
    end
endmodule

// File: rtl/tdm4_mux_tx.sv
// tdm4_mux_tx: four-channel round-robin TDM slot transmitter; TDM4_SKIP_EMPTY_EN skips empty slots
module tdm4_mux_tx
    import tdm4_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    input  logic [NUM_CH-1:0]       in_valid,
    output logic [NUM_CH-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [1:0]              out_slot,
    output logic                    out_full,
    output logic                    out_frame,
    output logic                    out_valid,
    input  logic                    out_ready
);
    state_t state, state_d;
    logic [NUM_CH-1:0] full, drain;
    logic [WIDTH-1:0] hold [NUM_CH];
    slot_t ls;
    logic load, done, hs;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        tdm4_chan_buf #(.WIDTH(WIDTH)) u_buf (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_data  (in_data[i*WIDTH +: WIDTH]),
            .in_valid (in_valid[i]),
            .drain    (drain[i]),
            .in_ready (in_ready[i]),
            .hold     (hold[i]),
            .full     (full[i])
        );
    end

    assign hs = out_valid & out_ready;
`ifdef TDM4_SKIP_EMPTY_EN
    logic found;
    assign {found, ls} = next_full(full, state == IDLE ? 2'd0 : out_slot + 2'd1);
    assign done = ~en & (hs | ~out_valid);
    assign load = (state == IDLE ? en : (hs | ~out_valid)) & found & ~done;
`else
    assign ls = state == IDLE ? 2'd0 : out_slot + 2'd1;
    // a stop request only ends the run once the whole frame has gone out
    assign done = ~en & hs & (out_slot == 2'd3);
    assign load = state == IDLE ? en : hs & ~done;
`endif
    assign drain = {NUM_CH{load}} & (NUM_CH'(1) << ls);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_d;
    end

    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (en ? RUN : IDLE) : done ? IDLE : en ? RUN : STOP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_slot  <= '0;
            out_full  <= 1'b0;
            out_frame <= 1'b0;
        end else begin
            out_valid <= load | (out_valid & ~out_ready);
            if (load) begin
                out_slot  <= ls;
                out_full  <= full[ls];
                out_data  <= full[ls] ? hold[ls] : '0;
                out_frame <= ls == 2'd0;
            end
        end
    end
endmodule

// File: tb/tb_tdm4_mux_tx.sv
// tb_tdm4_mux_tx: directed scoreboard bench for the four-channel TDM transmitter
module tb_tdm4_mux_tx;
    import tdm4_pkg::*;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           en = 1'b0;
    logic [4*W-1:0] in_data = '0;
    logic [3:0]     in_valid = '0;
    logic [3:0]     in_ready;
    logic [W-1:0]   out_data;
    logic [1:0]     out_slot;
    logic           out_full;
    logic           out_frame;
    logic           out_valid;
    logic           out_ready = 1'b1;

    typedef struct {
        logic [1:0] slot;
        logic       full;
        logic [7:0] data;
    } exp_t;

    exp_t sb[$];
    int n_checks = 0;
    int n_fail = 0;

    tdm4_mux_tx #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_slot  (out_slot),
        .out_full  (out_full),
        .out_frame (out_frame),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [1:0] s, input logic f, input logic [7:0] d);
        exp_t e;
        e.slot = s;
        e.full = f;
        e.data = d;
        sb.push_back(e);
    endtask

    // waits (bounded) for an accepted slot, compares it with the queue head, then steps one cycle
    task automatic check_one(input string tag);
        exp_t e;
        int t;
        t = 0;
        while (!(out_valid && out_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_handshake"}, 32'(out_valid && out_ready), 1);
        chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_slot"}, 32'(out_slot), 32'(e.slot));
            chk({tag, "_full"}, 32'(out_full), 32'(e.full));
            chk({tag, "_data"}, 32'(out_data), 32'(e.data));
            chk({tag, "_frame"}, 32'(out_frame), 32'(e.slot == 2'd0));
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0;
        in_valid = '0;
        out_ready = 1'b1;
        sb.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic load_ch(input int ch, input logic [7:0] d);
        in_data[ch*W +: W] = d;
        in_valid[ch] = 1'b1;
        @(negedge clk);
        in_valid[ch] = 1'b0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 0);
        chk({tag, "_slot"}, 32'(out_slot), 0);
        chk({tag, "_data"}, 32'(out_data), 0);
        chk({tag, "_full"}, 32'(out_full), 0);
        chk({tag, "_frame"}, 32'(out_frame), 0);
        chk({tag, "_in_ready"}, 32'(in_ready), 32'hF);
    endtask

    initial begin
        do_reset();
        chk_reset_values("reset");
`ifndef TDM4_SKIP_EMPTY_EN
        // empty channels: a fixed 0,1,2,3,0 slot stream with no words
        en = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 5; s++) push(2'(s), 1'b0, 8'h00);
        repeat (5) check_one("empty");
        do_reset();
        // preloaded ch0 and ch2
        in_data[0 +: W] = 8'hA5;
        in_data[2*W +: W] = 8'h3C;
        in_valid = 4'b0101;
        @(negedge clk);
        in_valid = '0;
        chk("preload_in_ready", 32'(in_ready), 32'hA);
        en = 1'b1;
        @(negedge clk);
        push(0, 1'b1, 8'hA5);
        push(1, 1'b0, 8'h00);
        push(2, 1'b1, 8'h3C);
        push(3, 1'b0, 8'h00);
        repeat (4) check_one("preload");
        chk("preload_in_ready_after", 32'(in_ready), 32'hF);
        do_reset();
        // backpressure on slot 1
        load_ch(1, 8'h11);
        en = 1'b1;
        @(negedge clk);
        push(0, 1'b0, 8'h00);
        check_one("stall_pre");
        out_ready = 1'b0;
        repeat (3) begin
            chk("stall_valid", 32'(out_valid), 1);
            chk("stall_slot", 32'(out_slot), 1);
            chk("stall_data", 32'(out_data), 32'h11);
            chk("stall_full", 32'(out_full), 1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        push(1, 1'b1, 8'h11);
        push(2, 1'b0, 8'h00);
        check_one("stall_slot1");
        chk("stall_release_slot", 32'(out_slot), 2);
        check_one("stall_slot2");
        do_reset();
        // en dropped during slot 1: frame completes, then idle
        en = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) push(2'(s), 1'b0, 8'h00);
        check_one("stop_s0");
        en = 1'b0;
        repeat (3) check_one("stop");
        chk("stop_valid", 32'(out_valid), 0);
        chk("stop_state", 32'(dut.state), 32'(IDLE));
        repeat (3) @(negedge clk);
        chk("stop_valid_later", 32'(out_valid), 0);
        do_reset();
        // asynchronous reset mid-frame with ch3 holding a word
        load_ch(3, 8'h99);
        en = 1'b1;
        @(negedge clk);
        push(0, 1'b0, 8'h00);
        check_one("midrst_s0");
        #1 rst_n = 1'b0;
        #1;
        chk_reset_values("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int s = 0; s < 4; s++) push(2'(s), 1'b0, 8'h00);
        repeat (4) check_one("midrst_after");
`else
        // only ch3 full: one word, then silence until another capture
        load_ch(3, 8'h77);
        en = 1'b1;
        @(negedge clk);
        push(3, 1'b1, 8'h77);
        check_one("skip_ch3");
        repeat (3) begin
            chk("skip_idle_valid", 32'(out_valid), 0);
            @(negedge clk);
        end
        push(1, 1'b1, 8'h55);
        load_ch(1, 8'h55);
        check_one("skip_ch1");
        chk("skip_in_ready", 32'(in_ready), 32'hF);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/tdm4_mux_tx.md
# tdm4_mux_tx

Four-channel time-division multiplexing transmitter: the sequential sender side of the 4:1 mux / 1:4 demux selector pair. It buffers one word per input channel and emits a round-robin slot stream. Each slot carries a word, a 2-bit slot number and frame/occupancy flags, so a downstream 1:4 demux can route it by `{s1,s0} = out_slot`. It sits between four independent producers and a single shared link with backpressure.

## Interface
- `WIDTH`, 8, data word width per channel.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `en`  in  1  run request; sampled every cycle.
- `in_data`  in  4*WIDTH  channel words; channel i at `[i*WIDTH +: WIDTH]`.
- `in_valid`  in  4  per-channel word offered.
- `in_ready`  out  4  per-channel holding register empty.
- `out_data`  out  WIDTH  slot word; 0 when slot empty.
- `out_slot`  out  2  slot number (demux selector `{s1,s0}`).
- `out_full`  out  1  slot carries a real word.
- `out_frame`  out  1  high when `out_slot == 0`.
- `out_valid`  out  1  slot presented.
- `out_ready`  in  1  link accepts slot.

## Operation
- Per channel: 1-entry holding register plus a full flag. Capture on `in_valid[i] & in_ready[i]`. `in_ready[i] = ~full[i]` is registered, so there is no same-cycle refill after a drain.
- Slot load: copies `hold[s]` to the output regs, sets `out_full=1` and clears `full[s]`. If the channel is empty: `out_data=0`, `out_full=0`.
- A word captured on the same edge as its slot load is not emitted; it waits for the next frame.
- FSM states: IDLE, RUN, STOP.
  - IDLE: `out_valid=0`. If `en=1`, load slot 0 at the next edge and go to RUN.
  - RUN: on `out_valid & out_ready`, load slot `(s+1) mod 4`, wrapping 3→0. If `en=0` is sampled, go to STOP.
  - STOP: keep advancing slots on handshakes until slot 3 is accepted, then go to IDLE with `out_valid=0`. If `en` returns to 1 while in STOP, go back to RUN; no frame is truncated.
- Output regs hold stable while `out_valid & ~out_ready`.
- Reset mid-frame: all state is discarded immediately, including buffered words; there is no partial-frame recovery.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_slot=0`, `out_full=0`, `out_frame=0`, `in_ready=4'hF`, FSM in IDLE, all full flags 0.
- IDLE → first slot: 1 cycle after `en` is sampled high.
- Throughput: 1 slot/cycle with `out_ready=1`; a frame is 4 cycles.
- Input-to-output latency: the word is captured at edge k and emitted at the first slot-i load at or after edge k+1. Worst case is 4 slots plus stall cycles.
- `in_ready[i]` rises 1 cycle after the slot-i load that drains channel i.

## Configuration
- Macro: `TDM4_SKIP_EMPTY_EN`.
- Without it: fixed TDM. Every slot is emitted, and empty slots use `out_full=0`.
- With it: the slot load picks the next full channel in round-robin order after the current slot.
  - If no channel is full, `out_valid` deasserts and the FSM stays in RUN until some channel fills; the load happens the cycle after that capture.
  - `out_full` is always 1 when `out_valid=1`.
  - STOP → IDLE happens after the current word is accepted.
  - `out_frame` still means `out_slot == 0`.

## Structure
- `tdm4_pkg`: `NUM_CH = 4`, `slot_t` (2-bit), `state_t` enum {IDLE, RUN, STOP}.
- Sub-module `tdm4_chan_buf`: one-entry holding register with full flag and ready, instantiated 4× (generate loop). The top holds the FSM, slot counter and output regs.

## Test plan
- Reset, then `en=1`, all channels empty, `out_ready=1`: slots 0,1,2,3,0 on consecutive cycles, `out_full=0`, `out_data=0`, `out_frame` high every 4th cycle.
- Preload ch0=0xA5, ch2=0x3C, then `en=1` → slot0 `{0xA5,full}`, slot1 empty, slot2 `{0x3C,full}`, slot3 empty; `in_ready` returns to 4'hF.
- `out_ready=0` for 3 cycles on slot 1 carrying 0x11 → outputs held unchanged, slot 2 appears 1 cycle after `out_ready` rises.
- `en` dropped during slot 1 → slots 2 and 3 still emitted, then `out_valid=0`; FSM in IDLE.
- `rst_n` asserted mid-frame with ch3 full → outputs immediately at reset values, `in_ready=4'hF`, ch3 word is never emitted.
- With `TDM4_SKIP_EMPTY_EN` defined, only ch3=0x77 full → a single `{slot 3, 0x77}` is emitted, then `out_valid=0` until the next capture.
